// File: rtl/xgemac_tx_arbiter.sv
// rtl/xgemac_tx_arbiter.sv - packet-atomic round-robin arbiter for the XGEMAC TX packet port
//
// Purpose:
//   Grants one of NUM_SRC packet sources at a time for a whole packet
//   (SOP through EOP) and forwards its beats to the MAC pkt_tx_* port
//   through one register stage, honouring pkt_tx_full backpressure.
//
// Ports:
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   src_data/val/sop/eop/mod   per-source beat inputs, source i at slice i
//   src_rdy         per-source ready; a beat moves on src_val[i] & src_rdy[i]
//   pkt_tx_data/val/sop/eop/mod   registered MAC beat outputs
//   pkt_tx_full     MAC FIFO full; blocks all accepts while high
//   owner, busy     granted source index and packet-in-progress flag
//   err             one-cycle pulse aligned with a malformed forwarded beat
module xgemac_tx_arbiter #(
   parameter int  NUM_SRC    = 2,
   parameter int  DATA_WIDTH = 64,
   parameter int  MOD_WIDTH  = 3,
   localparam int IDX_W      = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]            src_val,
   input  logic [NUM_SRC-1:0]            src_sop,
   input  logic [NUM_SRC-1:0]            src_eop,
   input  logic [NUM_SRC*MOD_WIDTH-1:0]  src_mod,
   output logic [NUM_SRC-1:0]            src_rdy,
   output logic [DATA_WIDTH-1:0]         pkt_tx_data,
   output logic                          pkt_tx_val,
   output logic                          pkt_tx_sop,
   output logic                          pkt_tx_eop,
   output logic [MOD_WIDTH-1:0]          pkt_tx_mod,
   input  logic                          pkt_tx_full,
   output logic [IDX_W-1:0]              owner,
   output logic                          busy,
   output logic                          err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_XFER = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_W-1:0]       last;
   logic                   first_beat;

   logic [NUM_SRC-1:0]     cand;
   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;

   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   sel_val;
   logic                   sel_sop;
   logic                   sel_eop;
   logic [MOD_WIDTH-1:0]   sel_mod;
   logic                   accept;

   // Only a beat carrying SOP may open a packet; a stray mid-packet beat
   // presented while idle just waits.
   assign cand = src_val & src_sop;

   // Round-robin search starting just after the last source to finish a
   // packet, so that source has the lowest priority next time.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!pick_found && cand[(int'(last) + k) % NUM_SRC]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(last) + k) % NUM_SRC);
         end
      end
   end

   always_comb begin
      sel_data = src_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      sel_val  = src_val[owner];
      sel_sop  = src_sop[owner];
      sel_eop  = src_eop[owner];
      sel_mod  = src_mod[int'(owner)*MOD_WIDTH +: MOD_WIDTH];
   end

   assign accept = (state == S_XFER) && sel_val && !pkt_tx_full;
   assign busy   = (state == S_XFER);

   // The full -> src_rdy path is the one combinational input-to-output path;
   // it lets a source stop within the same cycle the MAC fills.
   always_comb begin
      src_rdy = '0;
      if (state == S_XFER) begin
         src_rdy[owner] = !pkt_tx_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (pick_found) begin
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (accept && sel_eop) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= '0;
         last        <= IDX_W'(NUM_SRC - 1);
         first_beat  <= 1'b0;
         pkt_tx_data <= '0;
         pkt_tx_val  <= 1'b0;
         pkt_tx_sop  <= 1'b0;
         pkt_tx_eop  <= 1'b0;
         pkt_tx_mod  <= '0;
         err         <= 1'b0;
      end else begin
         if ((state == S_IDLE) && pick_found) begin
            owner      <= pick_idx;
            first_beat <= 1'b1;
         end
         if (accept) begin
            first_beat <= 1'b0;
            if (sel_eop) begin
               last <= owner;
            end
         end

         // Data/sop/eop/mod hold across idle cycles; only val drops.
         pkt_tx_val <= accept;
         if (accept) begin
            pkt_tx_data <= sel_data;
            pkt_tx_sop  <= sel_sop;
            pkt_tx_eop  <= sel_eop;
            pkt_tx_mod  <= sel_eop ? sel_mod : '0;
         end

         // The first beat must carry SOP and no later beat may; either
         // violation is still forwarded, just flagged.
         err <= accept && (first_beat ? !sel_sop : sel_sop);
      end
   end

endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// tb/tb_xgemac_tx_arbiter.sv - directed self-checking bench for xgemac_tx_arbiter
module tb_xgemac_tx_arbiter;

   localparam int NS = 2;
   localparam int DW = 64;
   localparam int MW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NS*DW-1:0]  src_data;
   logic [NS-1:0]     src_val;
   logic [NS-1:0]     src_sop;
   logic [NS-1:0]     src_eop;
   logic [NS*MW-1:0]  src_mod;
   logic [NS-1:0]     src_rdy;
   logic [DW-1:0]     pkt_tx_data;
   logic              pkt_tx_val;
   logic              pkt_tx_sop;
   logic              pkt_tx_eop;
   logic [MW-1:0]     pkt_tx_mod;
   logic              pkt_tx_full;
   logic [0:0]        owner;
   logic              busy;
   logic              err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   xgemac_tx_arbiter #(
      .NUM_SRC    (NS),
      .DATA_WIDTH (DW),
      .MOD_WIDTH  (MW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_data    (src_data),
      .src_val     (src_val),
      .src_sop     (src_sop),
      .src_eop     (src_eop),
      .src_mod     (src_mod),
      .src_rdy     (src_rdy),
      .pkt_tx_data (pkt_tx_data),
      .pkt_tx_val  (pkt_tx_val),
      .pkt_tx_sop  (pkt_tx_sop),
      .pkt_tx_eop  (pkt_tx_eop),
      .pkt_tx_mod  (pkt_tx_mod),
      .pkt_tx_full (pkt_tx_full),
      .owner       (owner),
      .busy        (busy),
      .err         (err)
   );

   // per-source beat lists presented in order, advancing on handshake
   logic [DW-1:0] b_data [NS][32];
   logic          b_sop  [NS][32];
   logic          b_eop  [NS][32];
   logic [MW-1:0] b_mod  [NS][32];
   int            b_len  [NS];
   int            b_ptr  [NS];
   logic          full_mask [64];

   logic          busy_h  [64];
   logic          err_h   [64];
   logic          val_h   [64];
   logic [0:0]    owner_h [64];
   logic [NS-1:0] rdy_h   [64];
   logic [DW-1:0] data_h  [64];

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic [MW-1:0] mod;
   } ent_t;
   ent_t log_q[$];

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         b_len[i] = 0;
         b_ptr[i] = 0;
      end
      for (int c = 0; c < 64; c++) full_mask[c] = 1'b0;
      log_q.delete();
   endtask

   task automatic add_beat(input int s, input logic [DW-1:0] d, input logic sop,
                           input logic eop, input logic [MW-1:0] m);
      b_data[s][b_len[s]] = d;
      b_sop[s][b_len[s]]  = sop;
      b_eop[s][b_len[s]]  = eop;
      b_mod[s][b_len[s]]  = m;
      b_len[s]++;
   endtask

   task automatic add_pkt(input int s, input int n, input logic [DW-1:0] base,
                          input logic [MW-1:0] m);
      for (int k = 0; k < n; k++) begin
         add_beat(s, base + DW'(k), (k == 0), (k == n - 1), (k == n - 1) ? m : 3'd0);
      end
   endtask

   task automatic drive_inputs(input int c);
      for (int i = 0; i < NS; i++) begin
         if (b_ptr[i] < b_len[i]) begin
            src_data[i*DW +: DW] = b_data[i][b_ptr[i]];
            src_val[i]           = 1'b1;
            src_sop[i]           = b_sop[i][b_ptr[i]];
            src_eop[i]           = b_eop[i][b_ptr[i]];
            src_mod[i*MW +: MW]  = b_mod[i][b_ptr[i]];
         end else begin
            src_data[i*DW +: DW] = '0;
            src_val[i]           = 1'b0;
            src_sop[i]           = 1'b0;
            src_eop[i]           = 1'b0;
            src_mod[i*MW +: MW]  = '0;
         end
      end
      pkt_tx_full = full_mask[c];
   endtask

   task automatic sample_outputs(input int c);
      ent_t e;
      busy_h[c]  = busy;
      err_h[c]   = err;
      val_h[c]   = pkt_tx_val;
      owner_h[c] = owner;
      rdy_h[c]   = src_rdy;
      data_h[c]  = pkt_tx_data;
      if (pkt_tx_val) begin
         e.cyc  = c;
         e.data = pkt_tx_data;
         e.sop  = pkt_tx_sop;
         e.eop  = pkt_tx_eop;
         e.mod  = pkt_tx_mod;
         log_q.push_back(e);
      end
      for (int i = 0; i < NS; i++) begin
         if (src_val[i] && src_rdy[i]) b_ptr[i]++;
      end
   endtask

   // entered and left just after a posedge; cycle c's inputs are applied there
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         drive_inputs(c);
         @(negedge clk);
         sample_outputs(c);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      src_data    = '0;
      src_val     = 2'b01;
      src_sop     = 2'b01;
      src_eop     = '0;
      src_mod     = '0;
      pkt_tx_full = 1'b0;
      #22;
      total++; if (pkt_tx_val !== 1'b0) begin $display("FAIL reset_val got %0b want 0", pkt_tx_val); bad++; end
      total++; if (pkt_tx_data !== '0) begin $display("FAIL reset_data got %0h want 0", pkt_tx_data); bad++; end
      total++; if ({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== 5'd0) begin $display("FAIL reset_flags got %0h want 0", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}); bad++; end
      total++; if (src_rdy !== 2'b00) begin $display("FAIL reset_rdy got %0b want 00", src_rdy); bad++; end
      total++; if ({owner, busy, err} !== 3'b000) begin $display("FAIL reset_owner_busy_err got %0b want 000", {owner, busy, err}); bad++; end
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      src_val = '0;
      src_sop = '0;
   endtask

   task automatic test_round_robin();
      int            exp_cyc [8] = '{2, 3, 5, 6, 8, 9, 11, 12};
      logic [DW-1:0] exp_d   [8] = '{64'h10, 64'h11, 64'h20, 64'h21, 64'h12, 64'h13, 64'h22, 64'h23};
      clear_src();
      add_pkt(0, 2, 64'h10, 3'd1);
      add_pkt(0, 2, 64'h12, 3'd2);
      add_pkt(1, 2, 64'h20, 3'd3);
      add_pkt(1, 2, 64'h22, 3'd4);
      run(15);
      total++; if (log_q.size() != 8) begin $display("FAIL rr_count got %0d want 8", log_q.size()); bad++; end
      for (int k = 0; k < 8 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k].cyc != exp_cyc[k] || log_q[k].data !== exp_d[k] || log_q[k].sop !== (k % 2 == 0) || log_q[k].eop !== (k % 2 == 1)) begin
            $display("FAIL rr_beat%0d got cyc=%0d d=%0h s=%0b e=%0b want cyc=%0d d=%0h", k, log_q[k].cyc, log_q[k].data, log_q[k].sop, log_q[k].eop, exp_cyc[k], exp_d[k]);
            bad++;
         end
      end
      total++; if ({owner_h[1], owner_h[4], owner_h[7], owner_h[10]} !== 4'b0101) begin $display("FAIL rr_order got %0b want 0101", {owner_h[1], owner_h[4], owner_h[7], owner_h[10]}); bad++; end
      total++; if ({val_h[4], val_h[7], val_h[10]} !== 3'b000) begin $display("FAIL rr_gaps got %0b want 000", {val_h[4], val_h[7], val_h[10]}); bad++; end
      for (int c = 0; c < 15; c++) begin
         total++; if (rdy_h[c] === 2'b11) begin $display("FAIL rr_two_ready cyc=%0d got 11 want one-hot", c); bad++; end
      end
   endtask

   task automatic test_single();
      clear_src();
      add_pkt(0, 4, 64'h1, 3'd5);
      run(8);
      total++; if (log_q.size() != 4) begin $display("FAIL single_count got %0d want 4", log_q.size()); bad++; end
      for (int k = 0; k < 4 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k].cyc != k + 2 || log_q[k].data !== DW'(k + 1) || log_q[k].sop !== (k == 0) || log_q[k].eop !== (k == 3) || log_q[k].mod !== ((k == 3) ? 3'd5 : 3'd0)) begin
            $display("FAIL single_beat%0d got cyc=%0d d=%0h s=%0b e=%0b m=%0d want cyc=%0d d=%0h", k, log_q[k].cyc, log_q[k].data, log_q[k].sop, log_q[k].eop, log_q[k].mod, k + 2, k + 1);
            bad++;
         end
      end
      for (int c = 1; c <= 4; c++) begin
         total++; if (busy_h[c] !== 1'b1 || owner_h[c] !== 1'b0) begin $display("FAIL single_busy cyc=%0d got busy=%0b owner=%0d want 1/0", c, busy_h[c], owner_h[c]); bad++; end
      end
      total++; if (busy_h[6] !== 1'b0) begin $display("FAIL single_busy_end got %0b want 0", busy_h[6]); bad++; end
      total++; if (busy_h[0] !== 1'b0 || rdy_h[0] !== 2'b00) begin $display("FAIL single_idle_cycle0 got busy=%0b rdy=%0b want 0/00", busy_h[0], rdy_h[0]); bad++; end
   endtask

   task automatic test_backpressure();
      int exp_cyc [5] = '{2, 3, 7, 8, 9};
      clear_src();
      add_pkt(1, 5, 64'h30, 3'd3);
      full_mask[3] = 1'b1;
      full_mask[4] = 1'b1;
      full_mask[5] = 1'b1;
      run(12);
      total++; if (log_q.size() != 5) begin $display("FAIL bp_count got %0d want 5", log_q.size()); bad++; end
      for (int k = 0; k < 5 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k].cyc != exp_cyc[k] || log_q[k].data !== DW'(64'h30 + k) || log_q[k].mod !== ((k == 4) ? 3'd3 : 3'd0)) begin
            $display("FAIL bp_beat%0d got cyc=%0d d=%0h m=%0d want cyc=%0d d=%0h", k, log_q[k].cyc, log_q[k].data, log_q[k].mod, exp_cyc[k], 64'h30 + k);
            bad++;
         end
      end
      total++; if ({rdy_h[3], rdy_h[4], rdy_h[5]} !== 6'b000000) begin $display("FAIL bp_rdy_low got %0b want 000000", {rdy_h[3], rdy_h[4], rdy_h[5]}); bad++; end
      total++; if (rdy_h[2] !== 2'b10 || rdy_h[6] !== 2'b10) begin $display("FAIL bp_rdy_high got %0b/%0b want 10/10", rdy_h[2], rdy_h[6]); bad++; end
      total++; if ({val_h[4], val_h[5], val_h[6]} !== 3'b000) begin $display("FAIL bp_gap got %0b want 000", {val_h[4], val_h[5], val_h[6]}); bad++; end
      total++; if (data_h[5] !== 64'h31) begin $display("FAIL bp_hold got %0h want 31", data_h[5]); bad++; end
   endtask

   task automatic test_protocol();
      int            exp_cyc [4] = '{2, 4, 5, 6};
      logic [DW-1:0] exp_d   [4] = '{64'h55, 64'h60, 64'h61, 64'h62};
      logic          exp_s   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic          exp_e   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [MW-1:0] exp_m   [4] = '{3'd7, 3'd0, 3'd0, 3'd2};
      clear_src();
      add_beat(0, 64'h99, 1'b0, 1'b0, 3'd0);
      add_beat(1, 64'h55, 1'b1, 1'b1, 3'd7);
      add_beat(1, 64'h60, 1'b1, 1'b0, 3'd0);
      add_beat(1, 64'h61, 1'b1, 1'b0, 3'd0);
      add_beat(1, 64'h62, 1'b0, 1'b1, 3'd2);
      run(12);
      total++; if (log_q.size() != 4) begin $display("FAIL proto_count got %0d want 4", log_q.size()); bad++; end
      for (int k = 0; k < 4 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k].cyc != exp_cyc[k] || log_q[k].data !== exp_d[k] || log_q[k].sop !== exp_s[k] || log_q[k].eop !== exp_e[k] || log_q[k].mod !== exp_m[k]) begin
            $display("FAIL proto_beat%0d got cyc=%0d d=%0h s=%0b e=%0b m=%0d want cyc=%0d d=%0h s=%0b e=%0b m=%0d", k, log_q[k].cyc, log_q[k].data, log_q[k].sop, log_q[k].eop, log_q[k].mod, exp_cyc[k], exp_d[k], exp_s[k], exp_e[k], exp_m[k]);
            bad++;
         end
      end
      total++; if (busy_h[2] !== 1'b0) begin $display("FAIL proto_single_idle got busy=%0b want 0", busy_h[2]); bad++; end
      for (int c = 0; c < 12; c++) begin
         total++; if (err_h[c] !== (c == 5)) begin $display("FAIL proto_err cyc=%0d got %0b want %0b", c, err_h[c], (c == 5)); bad++; end
         total++; if (rdy_h[c][0] !== 1'b0) begin $display("FAIL proto_nonsop_rdy cyc=%0d got 1 want 0", c); bad++; end
      end
      for (int c = 7; c < 12; c++) begin
         total++; if (busy_h[c] !== 1'b0) begin $display("FAIL proto_nonsop_busy cyc=%0d got %0b want 0", c, busy_h[c]); bad++; end
      end
   endtask

   task automatic test_reset_mid();
      clear_src();
      add_beat(0, 64'h6F, 1'b1, 1'b1, 3'd0);
      add_pkt(1, 5, 64'h70, 3'd1);
      run(4);
      drive_inputs(4);
      #2;
      total++; if (pkt_tx_val !== 1'b1 || pkt_tx_data !== 64'h70 || busy !== 1'b1 || owner !== 1'b1) begin
         $display("FAIL rstmid_pre got val=%0b d=%0h busy=%0b owner=%0d want 1/70/1/1", pkt_tx_val, pkt_tx_data, busy, owner); bad++; end
      rst_n = 1'b0;
      #1;
      total++; if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== 6'd0 || pkt_tx_data !== '0) begin
         $display("FAIL rstmid_pkt got val=%0b d=%0h want 0/0", pkt_tx_val, pkt_tx_data); bad++; end
      total++; if ({src_rdy, owner, busy, err} !== 5'd0) begin $display("FAIL rstmid_ctrl got %0b want 00000", {src_rdy, owner, busy, err}); bad++; end
      @(posedge clk);
      #1;
      clear_src();
      drive_inputs(0);
      rst_n = 1'b1;
      add_pkt(1, 2, 64'hA0, 3'd0);
      add_pkt(0, 2, 64'hB0, 3'd0);
      run(8);
      total++; if (busy_h[1] !== 1'b1 || owner_h[1] !== 1'b0) begin $display("FAIL rstmid_first_grant got busy=%0b owner=%0d want 1/0", busy_h[1], owner_h[1]); bad++; end
      total++; if (log_q.size() < 3 || log_q[0].data !== 64'hB0 || log_q[0].cyc != 2 || log_q[2].data !== 64'hA0 || log_q[2].cyc != 5) begin
         $display("FAIL rstmid_order got n=%0d want B0@2 then A0@5", log_q.size()); bad++; end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_protocol();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
